pipe_writeback: RTL and testbench
=================================

PIPE_WRITEBACK -- requirements
Module: pipe_writeback

Interface
REQ-001 Parameter: XLEN, 32, datapath width in bits.
REQ-002 Parameter: NREGS, 32, architectural register count; register index width is log2(NREGS).
REQ-003 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 valid_w  input  1  writeback-stage instruction is valid and retires this cycle.
REQ-006 reg_write_w  input  1  writeback-stage instruction writes the register file.
REQ-007 result_src_w  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-008 alu_result_w  input  XLEN  ALU result carried from the memory stage.
REQ-009 read_data_w  input  XLEN  load data carried from the memory stage.
REQ-010 pc_plus_4_w  input  XLEN  link address for JAL/JALR.
REQ-011 rd_w  input  5  destination register index.
REQ-012 rs1_d  input  5  decode-stage source 1 index.
REQ-013 rs2_d  input  5  decode-stage source 2 index.
REQ-014 rd1_d  output  XLEN  source 1 operand to decode.
REQ-015 rd2_d  output  XLEN  source 2 operand to decode.
REQ-016 result_w  output  XLEN  selected writeback value, also used by the forwarding paths.
REQ-017 wb_fire  output  1  a register write commits this cycle.
REQ-018 instret  output  64  count of retired instructions.

Function
REQ-019 result_w SHALL be combinational: alu_result_w for 00, read_data_w for 01, pc_plus_4_w for 10, and 0 for 11.
REQ-020 wb_fire SHALL equal valid_w AND reg_write_w AND (rd_w != 0).
REQ-021 When wb_fire is 1, register rd_w SHALL take the value result_w on the rising edge of clk.
REQ-022 Register x0 SHALL read 0 at all times and SHALL never be written; a write to rd_w = 0 is silently dropped.
REQ-023 rd1_d and rd2_d SHALL be combinational reads of the register array, with zero added latency.
REQ-024 rs1_d = rs2_d SHALL return the same value on both ports.
REQ-025 When valid_w is 0, reg_write_w, rd_w and result_src_w SHALL have no effect on any state.
REQ-026 instret SHALL increment by 1 on each rising edge of clk where valid_w is 1.
REQ-027 instret SHALL wrap from 2^64-1 to 0 without flagging the wrap.
REQ-028 A single cycle in which wb_fire is 1 and a read targets the same register SHALL follow REQ-040 and REQ-041.

Reset
REQ-029 While reset is 0, all registers x1..x(NREGS-1) SHALL clear to 0 and instret SHALL clear to 0, independent of clk.
REQ-030 Reset asserted mid-write SHALL discard the write; the register SHALL read 0 after reset.
REQ-031 During reset, rd1_d, rd2_d and instret SHALL read 0; result_w and wb_fire SHALL still follow their combinational definitions.
REQ-032 After reset deasserts, the first rising edge of clk with wb_fire = 1 SHALL commit normally.

Configuration
REQ-033 The macro WB_BYPASS_EN SHALL select write-through bypassing on the read ports.
REQ-034 With WB_BYPASS_EN defined: if wb_fire is 1 and rs1_d = rd_w (or rs2_d = rd_w), the matching port SHALL return result_w in the same cycle.
REQ-035 Without WB_BYPASS_EN: read ports SHALL return the stored value only; the new value SHALL be visible from the cycle after the write.
REQ-036 Without WB_BYPASS_EN, the hazard unit SHALL stall decode one extra cycle (documented here; not implemented in this block).

Structure
REQ-037 The shared package riscv_pkg SHALL hold XLEN, the result_src_t enum (RES_ALU, RES_MEM, RES_PC4, RES_RSVD) and the register index type reg_idx_t.
REQ-038 The register array SHALL be a sub-module regfile_bank with one synchronous write port, two combinational read ports and an asynchronous active-low clear.
REQ-039 pipe_writeback SHALL own the result mux, the write-enable logic, the bypass logic and the instret counter.

Verification
REQ-040 Bench (bypass enabled): valid_w=1, reg_write_w=1, src=00, alu=0xDEADBEEF, rd=5, rs1=5 -> rd1_d=0xDEADBEEF in the same cycle; x5=0xDEADBEEF after the edge.
REQ-041 Bench (bypass disabled): same stimulus as REQ-040 -> rd1_d=0 in the write cycle and 0xDEADBEEF in the next cycle.
REQ-042 Bench: write rd=0 with alu=0x1234, then rs1=0 -> rd1_d=0 and wb_fire=0.
REQ-043 Bench: src=01 with load=0xCAFE0001, then src=10 with pc4=0x80, writing rd=3 then rd=4 -> x3=0xCAFE0001 and x4=0x80; valid_w=0 with rd=3 -> x3 unchanged.
REQ-044 Bench: preload instret to 2^64-1 via forced valid cycles, then one valid_w -> instret=0.
REQ-045 Bench: write x7=0x55, then pull reset low for half a cycle -> x7=0 and instret=0 immediately, with no clk edge required.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the writeback slice: datapath width,
// register index type and the result-select encoding.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_t;

endpackage

// File: rtl/pipe_writeback_if.sv
// Writeback bundle: retiring instruction from the memory stage,
// decode-stage read ports, forwarded result and retire counter.
interface pipe_writeback_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    logic             valid_w;
    logic             reg_write_w;
    result_src_t      result_src_w;
    logic [XLEN-1:0]  alu_result_w;
    logic [XLEN-1:0]  read_data_w;
    logic [XLEN-1:0]  pc_plus_4_w;
    reg_idx_t         rd_w;
    reg_idx_t         rs1_d;
    reg_idx_t         rs2_d;
    logic [XLEN-1:0]  rd1_d;
    logic [XLEN-1:0]  rd2_d;
    logic [XLEN-1:0]  result_w;
    logic             wb_fire;
    logic [63:0]      instret;

    modport master (
        output valid_w, reg_write_w, result_src_w,
        output alu_result_w, read_data_w, pc_plus_4_w,
        output rd_w, rs1_d, rs2_d,
        input  rd1_d, rd2_d, result_w, wb_fire, instret
    );

    modport slave (
        input  valid_w, reg_write_w, result_src_w,
        input  alu_result_w, read_data_w, pc_plus_4_w,
        input  rd_w, rs1_d, rs2_d,
        output rd1_d, rd2_d, result_w, wb_fire, instret
    );

endinterface

// File: rtl/regfile_bank.sv
// Architectural register array: one synchronous write port, two
// combinational read ports, x0 hardwired to zero, async clear.
module regfile_bank #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];

    // clear everything on reset, otherwise commit the write (never x0)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/pipe_writeback.sv
// Writeback stage: result mux, write enable, optional write-through
// bypass (WB_BYPASS_EN) and the 64-bit retired-instruction counter.
module pipe_writeback #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic         clk,
    input  logic         reset,
    pipe_writeback_if.slave wb
);
    import riscv_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] result;
    logic            fire;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;

    // pick the value being written back; reserved encoding yields zero
    always_comb begin
        result = '0;
        unique case (wb.result_src_w)
            RES_ALU: result = wb.alu_result_w;
            RES_MEM: result = wb.read_data_w;
            RES_PC4: result = wb.pc_plus_4_w;
            default: result = '0;
        endcase
    end

    assign fire        = wb.valid_w & wb.reg_write_w & (wb.rd_w != '0);
    assign wb.result_w = result;
    assign wb.wb_fire  = fire;

    regfile_bank #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_bank (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (fire),
        .waddr_i  (wb.rd_w[AW-1:0]),
        .wdata_i  (result),
        .raddr1_i (wb.rs1_d[AW-1:0]),
        .raddr2_i (wb.rs2_d[AW-1:0]),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

`ifdef WB_BYPASS_EN
    // forward the in-flight write to a matching read port; the array
    // is being cleared during reset, so reads stay zero then
    always_comb begin
        wb.rd1_d = rf_rd1;
        wb.rd2_d = rf_rd2;
        if (reset && fire && (wb.rs1_d == wb.rd_w)) begin
            wb.rd1_d = result;
        end
        if (reset && fire && (wb.rs2_d == wb.rd_w)) begin
            wb.rd2_d = result;
        end
    end
`else
    assign wb.rd1_d = rf_rd1;
    assign wb.rd2_d = rf_rd2;
`endif

    // count each retiring instruction, wrapping silently
    always_comb begin
        instret_d = instret_q + {63'd0, wb.valid_w};
    end

    // retire counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign wb.instret = instret_q;

endmodule

// File: tb/tb_pipe_writeback.sv
// Self-checking bench for pipe_writeback: directed scenarios plus
// randomized traffic against a register-file reference model.
module tb_pipe_writeback;
    import riscv_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_writeback_if bus ();

    pipe_writeback dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mregs [32];
    logic [63:0] minst;

    function automatic logic [31:0] m_res();
        logic [1:0] s;
        s = bus.result_src_w;
        case (s)
            2'd0:    return bus.alu_result_w;
            2'd1:    return bus.read_data_w;
            2'd2:    return bus.pc_plus_4_w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_fire();
        return bus.valid_w && bus.reg_write_w && (bus.rd_w != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (!reset || rs == 5'd0) return 32'd0;
        if (BYP && m_fire() && rs == bus.rd_w) return m_res();
        return mregs[rs];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        minst = 64'd0;
    endtask

    task automatic drive(input logic v, input logic rw,
                         input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.valid_w      = v;
        bus.reg_write_w  = rw;
        bus.result_src_w = result_src_t'(src);
        bus.alu_result_w = alu;
        bus.read_data_w  = ld;
        bus.pc_plus_4_w  = pc4;
        bus.rd_w         = rd;
        bus.rs1_d        = rs1;
        bus.rs2_d        = rs2;
    endtask

    // one rising edge, with the model following the architectural rules
    task automatic step();
        logic        do_w;
        logic        inc;
        logic [4:0]  a;
        logic [31:0] v;
        do_w = m_fire() && reset;
        inc  = bus.valid_w && reset;
        a    = bus.rd_w;
        v    = m_res();
        @(posedge clk);
        if (do_w) mregs[a] = v;
        if (inc) minst = minst + 64'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_clear();
        drive(1, 1, 2'd0, 32'hA5A5_0001, 0, 0, 5'd5, 5'd5, 5'd5);
        @(negedge clk);
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL rst_rd1 got %h exp 0", bus.rd1_d); end
        nvec++; if (bus.rd2_d !== 32'd0) begin nerr++; $display("FAIL rst_rd2 got %h exp 0", bus.rd2_d); end
        nvec++; if (bus.instret !== 64'd0) begin nerr++; $display("FAIL rst_instret got %h exp 0", bus.instret); end
        nvec++; if (bus.wb_fire !== 1'b1) begin nerr++; $display("FAIL rst_fire got %b exp 1", bus.wb_fire); end
        nvec++; if (bus.result_w !== 32'hA5A5_0001) begin nerr++; $display("FAIL rst_result got %h exp a5a50001", bus.result_w); end
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        drive(1, 1, 2'd0, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd5, 5'd0);
        #1;
        exp = BYP ? 32'hDEAD_BEEF : 32'd0;
        nvec++; if (bus.rd1_d !== exp) begin nerr++; $display("FAIL byp_same_cycle got %h exp %h", bus.rd1_d, exp); end
        nvec++; if (bus.rd2_d !== 32'd0) begin nerr++; $display("FAIL byp_rd2_x0 got %h exp 0", bus.rd2_d); end
        nvec++; if (bus.wb_fire !== 1'b1) begin nerr++; $display("FAIL byp_fire got %b exp 1", bus.wb_fire); end
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd5, 5'd5);
        #1;
        nvec++; if (bus.rd1_d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL byp_next_rd1 got %h exp deadbeef", bus.rd1_d); end
        nvec++; if (bus.rd2_d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL byp_next_rd2 got %h exp deadbeef", bus.rd2_d); end
        nvec++; if (bus.instret !== minst) begin nerr++; $display("FAIL byp_instret got %h exp %h", bus.instret, minst); end
        step();
    endtask

    task automatic test_x0();
        drive(1, 1, 2'd0, 32'h0000_1234, 0, 0, 5'd0, 5'd0, 5'd0);
        #1;
        nvec++; if (bus.wb_fire !== 1'b0) begin nerr++; $display("FAIL x0_fire got %b exp 0", bus.wb_fire); end
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL x0_same got %h exp 0", bus.rd1_d); end
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL x0_after got %h exp 0", bus.rd1_d); end
        step();
    endtask

    task automatic test_result_src();
        drive(1, 1, 2'd1, 32'h111, 32'hCAFE_0001, 32'h222, 5'd3, 5'd3, 5'd4);
        #1;
        nvec++; if (bus.result_w !== 32'hCAFE_0001) begin nerr++; $display("FAIL src_load got %h exp cafe0001", bus.result_w); end
        step();
        drive(1, 1, 2'd2, 32'h333, 32'h444, 32'h80, 5'd4, 5'd3, 5'd4);
        #1;
        nvec++; if (bus.result_w !== 32'h80) begin nerr++; $display("FAIL src_pc4 got %h exp 80", bus.result_w); end
        step();
        drive(0, 1, 2'd0, 32'hFFFF, 0, 0, 5'd3, 5'd3, 5'd4);
        #1;
        nvec++; if (bus.wb_fire !== 1'b0) begin nerr++; $display("FAIL inval_fire got %b exp 0", bus.wb_fire); end
        step();
        drive(1, 1, 2'd3, 32'h555, 32'h666, 32'h777, 5'd6, 5'd3, 5'd4);
        #1;
        nvec++; if (bus.result_w !== 32'd0) begin nerr++; $display("FAIL src_rsvd got %h exp 0", bus.result_w); end
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd3, 5'd4);
        #1;
        nvec++; if (bus.rd1_d !== 32'hCAFE_0001) begin nerr++; $display("FAIL x3_hold got %h exp cafe0001", bus.rd1_d); end
        nvec++; if (bus.rd2_d !== 32'h80) begin nerr++; $display("FAIL x4_val got %h exp 80", bus.rd2_d); end
        bus.rs1_d = 5'd6;
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL x6_rsvd got %h exp 0", bus.rd1_d); end
        step();
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            #1;
            e = m_res();
            nvec++; if (bus.result_w !== e) begin nerr++; $display("FAIL rnd_result n=%0d got %h exp %h", n, bus.result_w, e); end
            nvec++; if (bus.wb_fire !== m_fire()) begin nerr++; $display("FAIL rnd_fire n=%0d got %b exp %b", n, bus.wb_fire, m_fire()); end
            e = m_read(bus.rs1_d);
            nvec++; if (bus.rd1_d !== e) begin nerr++; $display("FAIL rnd_rd1 n=%0d got %h exp %h", n, bus.rd1_d, e); end
            e = m_read(bus.rs2_d);
            nvec++; if (bus.rd2_d !== e) begin nerr++; $display("FAIL rnd_rd2 n=%0d got %h exp %h", n, bus.rd2_d, e); end
            nvec++; if (bus.instret !== minst) begin nerr++; $display("FAIL rnd_instret n=%0d got %h exp %h", n, bus.instret, minst); end
            step();
        end
    endtask

    task automatic test_instret_wrap();
        drive(1, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        release dut.instret_d;
        minst = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.valid_w = 1'b0;
        #1;
        bus.valid_w = 1'b1;
        #1;
        nvec++; if (bus.instret !== minst) begin nerr++; $display("FAIL inst_preload got %h exp %h", bus.instret, minst); end
        step();
        nvec++; if (bus.instret !== 64'd0) begin nerr++; $display("FAIL inst_wrap got %h exp 0", bus.instret); end
        bus.valid_w = 1'b0;
    endtask

    task automatic test_reset_async();
        drive(1, 1, 2'd0, 32'h55, 0, 0, 5'd7, 5'd7, 5'd7);
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd7, 5'd7);
        #1;
        nvec++; if (bus.rd1_d !== 32'h55) begin nerr++; $display("FAIL x7_write got %h exp 55", bus.rd1_d); end
        reset = 1'b0;
        m_clear();
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL async_x7 got %h exp 0", bus.rd1_d); end
        nvec++; if (bus.instret !== 64'd0) begin nerr++; $display("FAIL async_instret got %h exp 0", bus.instret); end
        #2;
        reset = 1'b1;
        @(negedge clk);
        drive(1, 1, 2'd0, 32'h99, 0, 0, 5'd9, 5'd9, 5'd9);
        reset = 1'b0;
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL midwr_rd1 got %h exp 0", bus.rd1_d); end
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd9, 5'd9);
        reset = 1'b1;
        #1;
        nvec++; if (bus.rd1_d !== 32'd0) begin nerr++; $display("FAIL midwr_x9 got %h exp 0", bus.rd1_d); end
        step();
        drive(1, 1, 2'd0, 32'h77, 0, 0, 5'd9, 5'd0, 5'd0);
        step();
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd9, 5'd0);
        #1;
        nvec++; if (bus.rd1_d !== 32'h77) begin nerr++; $display("FAIL post_rst_wr got %h exp 77", bus.rd1_d); end
        step();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_result_src();
        test_random();
        test_instret_wrap();
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
